// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle data-memory sequencer for the MEM stage.
//
// Takes decoded load/store controls and an effective address, and runs one
// request/response transaction with a variable-latency data memory. While the
// transaction runs, the upstream pipeline is stalled. The block forms the
// word address, byte mask and lane-replicated store data. It extracts and
// extends the load result. It flags misaligned or illegal accesses and
// abandons the access with a bus error if the memory does not finish in time.
//
// Ports
//   i_clk, i_rst_n         clock (rising edge), async active-low reset
//   i_valid                MEM stage holds a valid instruction
//   i_is_load, i_mem_wen   load / store controls (load wins if both are set)
//   i_size, i_unsigned     00 byte, 01 half, 10 word, 11 illegal; zero-extend
//   i_addr, i_wdata        effective byte address, store data
//   o_stall                freeze the pipeline upstream of WB
//   o_misalign             misaligned/illegal op seen in IDLE (no request)
//   o_rdata, o_rdata_valid extended load result, valid in DONE
//   o_bus_err              access abandoned on timeout (one cycle, in DONE)
//   o_mem_req/addr/wen/mask/wdata   registered memory request
//   i_mem_ready, i_mem_rvalid, i_mem_rdata   memory handshake / read data
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an op; aligned op is captured, misaligned flagged
// REQ   | o_mem_req asserted until i_mem_ready
// WAIT  | load accepted, waiting for i_mem_rvalid
// DONE  | one-cycle completion: pipeline advances, result/bus error shown

module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_load,
  input  logic        i_mem_wen,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_misalign,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [3:0]  o_mem_mask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  // The counter only needs to reach TIMEOUT_CYCLES-1: the cycle on which it
  // holds that value is the last one allowed in REQ+WAIT.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             uns_q;

  logic        op;
  logic        misaligned;
  logic        aligned_op;
  logic        capture;
  logic        timeout;
  logic        rd_done;
  logic        to_err;
  logic [3:0]  mask_d;
  logic [31:0] wdata_d;
  logic [31:0] rd_shifted;
  logic [31:0] rd_ext;

  assign op         = i_valid & (i_is_load | i_mem_wen);
  assign aligned_op = op & ~misaligned;
  assign capture    = (state_q == S_IDLE) & aligned_op;
  assign timeout    = (cnt_q == CNT_LAST);

  always_comb begin
    misaligned = 1'b0;
    case (i_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_addr[0];
      2'b10:   misaligned = |i_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    mask_d  = 4'b1111;
    wdata_d = i_wdata;
    case (i_size)
      2'b00: begin
        mask_d  = 4'b0001 << i_addr[1:0];
        wdata_d = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        mask_d  = 4'b0011 << i_addr[1:0];
        wdata_d = {2{i_wdata[15:0]}};
      end
      default: begin
        mask_d  = 4'b1111;
        wdata_d = i_wdata;
      end
    endcase
  end

  // Load extraction uses only the captured size/offset/unsigned flags.
  always_comb begin
    rd_shifted = i_mem_rdata >> {off_q, 3'b000};
    rd_ext     = rd_shifted;
    case (size_q)
      2'b00:   rd_ext = {{24{~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   rd_ext = {{16{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  // Completion beats the timeout on the same cycle: an accepted store or a
  // returned read word is a finished access. A load accepted on the last
  // allowed cycle cannot finish in time, so it still times out.
  assign rd_done = (state_q == S_WAIT) & i_mem_rvalid;
  assign to_err  = timeout &
                   (((state_q == S_REQ)  & ~(i_mem_ready & o_mem_wen)) |
                    ((state_q == S_WAIT) & ~i_mem_rvalid));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: if (aligned_op) state_nx = S_REQ;
      S_REQ: begin
        if (i_mem_ready && o_mem_wen) state_nx = S_DONE;
        else if (timeout)             state_nx = S_DONE;
        else if (i_mem_ready)         state_nx = S_WAIT;
      end
      S_WAIT:  if (i_mem_rvalid || timeout) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state and inputs
  always_comb begin
    o_stall    = 1'b0;
    o_misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_stall    = aligned_op;
        o_misalign = op & misaligned;
      end
      S_REQ, S_WAIT: o_stall = 1'b1;
      default: o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req     <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wen     <= 1'b0;
      o_mem_mask    <= '0;
      o_mem_wdata   <= '0;
      size_q        <= '0;
      off_q         <= '0;
      uns_q         <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_bus_err     <= 1'b0;
    end else begin
      if (capture) begin
        o_mem_addr  <= {i_addr[31:2], 2'b00};
        o_mem_wen   <= ~i_is_load;
        o_mem_mask  <= mask_d;
        o_mem_wdata <= wdata_d;
        size_q      <= i_size;
        off_q       <= i_addr[1:0];
        uns_q       <= i_unsigned;
      end
      o_mem_req     <= (state_nx == S_REQ);
      o_rdata_valid <= rd_done;
      o_bus_err     <= to_err;
      if (rd_done)     o_rdata <= rd_ext;
      else if (to_err) o_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl. A driver issues ops and pushes the
// expected memory request and response into queues; a memory responder
// answers requests with configured latencies; a monitor compares whatever the
// DUT presents against the queue heads.

module tb_mem_access_ctrl;

  localparam int T = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_is_load, i_mem_wen, i_unsigned;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall, o_misalign, o_rdata_valid, o_bus_err;
  logic        o_mem_req, o_mem_wen;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .i_is_load(i_is_load), .i_mem_wen(i_mem_wen),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_misalign(o_misalign), .o_rdata(o_rdata),
    .o_rdata_valid(o_rdata_valid), .o_bus_err(o_bus_err),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
    .o_mem_mask(o_mem_mask), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          err;
    bit          ld;
    logic [31:0] data;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int errors = 0;

  // responder configuration for the op in flight
  int          rd_cfg = 0;
  int          rv_cfg = 1;
  logic [31:0] rdat_cfg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extraction: pick the addressed bytes arithmetically and
  // sign-extend by subtracting the span when the value is in the upper half.
  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] sz, input bit uns);
    longint v, span;
    v = longint'(w >> (8 * off));
    span = (sz == 0) ? 256 : (sz == 1) ? 65536 : 64'h1_0000_0000;
    v = v % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Memory responder: ready after rd_cfg REQ cycles; read data rv_cfg cycles
  // after acceptance (0 = never). Spurious rvalid is injected outside WAIT.
  int req_cnt = 0;
  int rv_cnt = 0;
  bit active = 0;
  always @(negedge i_clk) begin
    if (o_mem_req) begin
      active = 0;
      i_mem_ready = (req_cnt == rd_cfg);
      req_cnt++;
      if (i_mem_ready && !o_mem_wen) begin
        active = 1;
        rv_cnt = 0;
      end
      i_mem_rvalid = ($urandom_range(0, 3) == 0);
      i_mem_rdata = $urandom;
    end else begin
      req_cnt = 0;
      i_mem_ready = ($urandom_range(0, 3) == 0);
      if (active) begin
        rv_cnt++;
        if (rv_cnt == rv_cfg) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata = rdat_cfg;
          active = 0;
        end else begin
          i_mem_rvalid = 1'b0;
          i_mem_rdata = $urandom;
        end
      end else begin
        i_mem_rvalid = ($urandom_range(0, 3) == 0);
        i_mem_rdata = $urandom;
      end
    end
  end

  // Monitor
  bit          prev_req = 0;
  logic [31:0] exp_hold = '0;
  req_t        mon_req;
  rsp_t        mon_rsp;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_req = 0;
      exp_hold = '0;
    end else begin
      if (o_mem_req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h with no request expected", o_mem_addr);
        end else begin
          mon_req = req_q[0];
          chk("req_addr", o_mem_addr, mon_req.addr);
          chk("req_wen", o_mem_wen, mon_req.wen);
          chk("req_mask", o_mem_mask, mon_req.mask);
          chk("req_wdata", o_mem_wdata, mon_req.wdata);
        end
      end else if (prev_req && req_q.size() > 0) begin
        void'(req_q.pop_front());
      end
      prev_req = o_mem_req;
      if (o_rdata_valid || o_bus_err) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got valid %b err %b with no response expected",
                   o_rdata_valid, o_bus_err);
        end else begin
          mon_rsp = rsp_q.pop_front();
          chk("bus_err", o_bus_err, mon_rsp.err);
          chk("rdata_valid", o_rdata_valid, !mon_rsp.err);
          chk("rdata", o_rdata, mon_rsp.err ? 32'h0 : mon_rsp.data);
          exp_hold = mon_rsp.err ? 32'h0 : mon_rsp.data;
        end
      end
      chk("rdata_hold", o_rdata, exp_hold);
    end
  end

  task automatic scramble();
    i_addr = $urandom;
    i_wdata = $urandom;
    i_size = 2'($urandom_range(0, 3));
    i_unsigned = 1'($urandom_range(0, 1));
    i_is_load = 1'($urandom_range(0, 1));
    i_mem_wen = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    @(posedge i_clk); #1;
    scramble();
    i_valid = 1'($urandom_range(0, 1));
    i_is_load = 1'b0;
    i_mem_wen = 1'b0;
    @(negedge i_clk);
    chk("idle_stall", o_stall, 0);
    chk("idle_misalign", o_misalign, 0);
  endtask

  task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int rd, input int rv, input logic [31:0] rdw);
    bit mis, err;
    int total, busy, n;
    logic [3:0] m;
    logic [31:0] rep;
    mis = (sz == 3) || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_is_load = ld; i_mem_wen = st; i_size = sz;
    i_unsigned = uns; i_addr = addr; i_wdata = wd;
    rd_cfg = rd; rv_cfg = rv; rdat_cfg = rdw;
    if (mis) begin
      @(negedge i_clk);
      chk("misalign", o_misalign, 1);
      chk("misalign_stall", o_stall, 0);
      chk("misalign_req", o_mem_req, 0);
      return;
    end
    total = ld ? ((rv == 0) ? 1000 : rd + 1 + rv) : rd + 1;
    err = total > T;
    busy = err ? T : total;
    m = (sz == 0) ? 4'(1 << (addr % 4)) : (sz == 1) ? 4'(3 << (addr % 4)) : 4'hF;
    rep = (sz == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
          (sz == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    req_q.push_back('{addr - addr % 4, !ld, m, rep});
    if (ld || err) rsp_q.push_back('{err, ld, err ? 32'h0 : ld_ext(rdw, 2'(addr % 4), sz, uns)});
    @(negedge i_clk);
    chk("aligned_no_misalign", o_misalign, 0);
    n = 0;
    while (o_stall && n < 60) begin
      n++;
      @(posedge i_clk); #1;
      scramble();
      @(negedge i_clk);
    end
    chk("stall_cycles", n, busy + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld, st;
    logic [1:0] sz;
    logic [31:0] a;
    int rd, rv, r;
    i_rst_n = 1'b0; i_valid = 1'b0; i_is_load = 1'b0; i_mem_wen = 1'b0;
    i_size = 2'b00; i_unsigned = 1'b0; i_addr = '0; i_wdata = '0;
    #2;
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_mask", o_mem_mask, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rvalid", o_rdata_valid, 0);
    chk("rst_bus_err", o_bus_err, 0);
    i_valid = 1'b1; i_is_load = 1'b1; i_size = 2'b10; i_addr = 32'h100;
    #1;
    chk("rst_stall_aligned_op", o_stall, 1);
    chk("rst_req_aligned_op", o_mem_req, 0);
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // directed cases
    do_op(0, 1, 2'b00, 0, 32'h0000_1003, 32'hAABB_CCDD, 0, 1, 32'h0);
    do_op(1, 0, 2'b01, 0, 32'h0000_2002, 32'h0, 0, 2, 32'h8123_4567);
    do_op(1, 0, 2'b01, 1, 32'h0000_2002, 32'h0, 0, 2, 32'h8123_4567);
    do_op(1, 0, 2'b10, 0, 32'h0000_0006, 32'h0, 0, 1, 32'h0);
    do_op(0, 1, 2'b10, 0, 32'h0000_3004, 32'h1234_5678, 3, 1, 32'h0);
    do_op(1, 0, 2'b10, 0, 32'h0000_4000, 32'h0, 0, 0, 32'h0);
    do_op(1, 0, 2'b00, 0, 32'h0000_0013, 32'h0, 1, 1, 32'h80FF_FFFF);
    do_op(1, 1, 2'b00, 1, 32'h0000_0011, 32'h5555_5555, 0, 3, 32'h0000_9A00);
    do_op(0, 1, 2'b11, 0, 32'h0000_0020, 32'h0, 0, 1, 32'h0);
    do_op(0, 1, 2'b01, 0, 32'h0000_0021, 32'h0, 0, 1, 32'h0);
    do_op(0, 1, 2'b01, 0, 32'h0000_0022, 32'hCAFE_BEEF, 20, 1, 32'h0);
    do_op(1, 0, 2'b10, 0, 32'h0000_0030, 32'h0, 3, 4, 32'hDEAD_BEEF);
    do_op(0, 1, 2'b10, 0, 32'h0000_0034, 32'h0BAD_F00D, 7, 1, 32'h0);
    do_op(1, 0, 2'b10, 0, 32'h0000_0038, 32'h0, 7, 1, 32'h1111_2222);

    // reset while waiting for read data
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_is_load = 1'b1; i_mem_wen = 1'b0; i_size = 2'b10;
    i_unsigned = 1'b0; i_addr = 32'h0000_0040; i_wdata = '0;
    rd_cfg = 0; rv_cfg = 0; rdat_cfg = '0;
    req_q.push_back('{32'h0000_0040, 1'b0, 4'hF, 32'h0});
    @(negedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("rst_wait_req", o_mem_req, 0);
    chk("rst_wait_stall", o_stall, 0);
    chk("rst_wait_addr", o_mem_addr, 0);
    chk("rst_wait_rdata", o_rdata, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    do_op(1, 0, 2'b00, 0, 32'h0000_0043, 32'h0, 0, 1, 32'hF000_0000);

    // randomized ops
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      r = $urandom_range(0, 2);
      ld = (r != 1);
      st = (r != 0);
      r = $urandom_range(0, 7);
      sz = (r < 7) ? 2'(r % 3) : 2'b11;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a = a - a % 2;
        if (sz == 2) a = a - a % 4;
      end
      r = $urandom_range(0, 9);
      rd = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? 7 : (r == 8) ? 8 : 20;
      rv = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      do_op(ld, st, sz, 1'($urandom_range(0, 1)), a, $urandom, rd, rv, $urandom);
    end

    idle_cycle();
    idle_cycle();
    chk("req_q_drained", req_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory sequencer for the MEM stage. Takes the decoded load/store controls (load flag, store enable, byte/half/word size, unsigned-load flag) plus the effective address and store data. Runs a request/response handshake with a variable-latency data memory and stalls the pipeline until the access finishes. It forms word-aligned addresses, byte masks and replicated store data, extracts and sign/zero-extends load results, and flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT before the access is abandoned with a bus error; must be ≥1.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  MEM stage holds a valid instruction.
- i_is_load  in  1  load instruction.
- i_mem_wen  in  1  store instruction; if both are set, load wins.
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- i_unsigned  in  1  zero-extend the load (lbu/lhu).
- i_addr  in  32  effective byte address.
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  freeze PC and all pipeline registers upstream of WB.
- o_misalign  out  1  misaligned/illegal access detected; no memory request is issued.
- o_rdata  out  32  extended load result.
- o_rdata_valid  out  1  o_rdata is valid this cycle.
- o_bus_err  out  1  access timed out.
- o_mem_req  out  1  memory request valid.
- o_mem_addr  out  32  word address, {addr[31:2],2'b00}.
- o_mem_wen  out  1  request is a write.
- o_mem_mask  out  4  byte enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  32  read word.

## Operation
- An op is `i_valid & (i_is_load | i_mem_wen)`.
- Misaligned when:
  - size 01 and addr[0] = 1;
  - size 10 and addr[1:0] ≠ 0;
  - size 11 with any address.
- Byte mask:
  - byte: 0001 << addr[1:0];
  - half: 0011 << addr[1:0];
  - word: 1111.
- Store data:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- Load data: shift i_mem_rdata right by 8·addr[1:0], then take 8/16/32 bits and sign- or zero-extend per the captured i_unsigned.
- FSM states and transitions:
  - IDLE: when an op is present and aligned, capture addr, size, unsigned, load/store, mask and wdata into registers, then go to REQ. When an op is present and misaligned, o_misalign = 1 combinationally, no stall, stay in IDLE.
  - REQ: drive o_mem_req plus the registered addr/wen/mask/wdata. When i_mem_ready is high, go to WAIT for a load or DONE for a store.
  - WAIT: sample i_mem_rvalid, starting the cycle after acceptance. When high, register the extended result into o_rdata and go to DONE.
  - DONE: o_rdata_valid = 1 for a load, o_stall = 0 for one cycle, then go to IDLE.
- o_stall = (IDLE & aligned op) | REQ | WAIT.
- Timeout: a counter clears on leaving IDLE and increments in REQ/WAIT. When it reaches TIMEOUT_CYCLES, go to DONE with o_bus_err = 1, o_rdata = 0 and o_rdata_valid = 0; o_mem_req drops.
- Input changes after leaving IDLE are ignored; the captured registers govern the access.
- i_mem_rvalid outside WAIT is ignored.
- o_rdata holds its value until the next load completes.

## Timing
- Reset values (asynchronous, immediate): state IDLE; o_stall 0 (unless an aligned op is present in IDLE); o_mem_req 0; o_mem_addr 0; o_mem_wen 0; o_mem_mask 0; o_mem_wdata 0; o_rdata 0; o_rdata_valid 0; o_bus_err 0; counter 0.
- Reset during REQ or WAIT: o_mem_req drops immediately and the transaction is abandoned.
- Zero-wait store: 3 cycles (IDLE stall, REQ accepted, DONE).
- Zero-wait load with rvalid one cycle after acceptance: 4 cycles (IDLE, REQ, WAIT, DONE).
- Each extra ready or rvalid wait cycle adds one cycle.
- Back-to-back ops: the DONE cycle advances the pipeline. The next op is evaluated in the following IDLE cycle, so there is no bubble beyond the IDLE cycle.
- o_mem_* are driven from registers only.
- o_stall and o_misalign are combinational from state and inputs.

## Test plan
- Store byte, addr 0x1003, wdata 0xAABBCCDD, i_mem_ready held 1 -> one REQ cycle with addr 0x1000, mask 1000, wdata 0xDDDDDDDD, wen 1; stall for 2 cycles, DONE in cycle 3.
- lh, addr 0x2002, rdata 0x8123_4567 returned 2 cycles after accept -> o_rdata 0xFFFF8123 with o_rdata_valid in DONE; lhu gives 0x00008123.
- lw, addr 0x0006 -> o_misalign 1, o_stall 0, o_mem_req never asserted.
- i_mem_ready low for 3 cycles, then high -> o_mem_req and signals stable for 4 cycles; o_stall stays 1 throughout.
- TIMEOUT_CYCLES = 4, load with rvalid never asserted -> DONE after 4 cycles in REQ+WAIT, o_bus_err 1 for one cycle, o_rdata 0.
- i_rst_n low mid-WAIT -> o_mem_req, o_stall and state cleared within the same cycle; the next aligned op restarts from IDLE.
